// File: rtl/counter_pkg.sv
// Direction and boundary-mode encodings shared by the counter and timer blocks.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of the modulo counter: the master drives the controls,
// the counter (slave) returns the count, terminal-count pulse and prescaler tick.
interface mod_counter_if #(
  parameter int WIDTH = 7
);

  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             tick;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  cnt, tc, tick
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output cnt, tc, tick
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler producing a count tick every PRESCALE enabled cycles; restart
// (clear or load) returns it to the start of a period.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam logic [PW-1:0] LAST_C = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_q;
      logic [PW-1:0] pre_d;

      assign tick_o = en_i && (pre_q == LAST_C);

      // prescaler next state: restart beats tick, frozen while disabled
      always_comb begin
        pre_d = pre_q;
        if (restart_i) begin
          pre_d = {PW{1'b0}};
        end else if (tick_o) begin
          pre_d = {PW{1'b0}};
        end else if (en_i) begin
          pre_d = pre_q + PW'(1);
        end else begin
          pre_d = pre_q;
        end
      end

      // prescaler register with synchronous reset
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pre_q <= {PW{1'b0}};
        end else begin
          pre_q <= pre_d;
        end
      end
    end else begin : g_nopre
      logic unused_s;
      assign unused_s = &{1'b0, clk, rst_n, restart_i};
      assign tick_o   = en_i;
    end
  endgenerate

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with clear, clamped parallel load, prescaled tick,
// wrap or saturate at the boundaries, and a registered terminal-count pulse.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int MAX_VAL  = 99,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input logic         clk,
  input logic         rst_n,
  mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_C   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C    = WIDTH'(1);
  localparam logic             SAT_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_q;
  logic             tc_d;
  logic             tick_s;
  logic             restart_s;
  logic             at_bound_s;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  assign restart_s = bus.clr | bus.load;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart_s),
    .en_i      (bus.en),
    .tick_o    (tick_s)
  );

  assign at_bound_s = (bus.up_dn == DIR_UP) ? (cnt_q == MAX_C) : (cnt_q == ZERO_C);

  // next count: clear > load > tick; out-of-range values fall back to 0 going up
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (bus.clr) begin
      cnt_d = ZERO_C;
    end else if (bus.load) begin
      cnt_d = clamp_load(bus.load_val);
    end else if (tick_s) begin
      tc_d = at_bound_s;
      if (bus.up_dn == DIR_UP) begin
        if (cnt_q == MAX_C) begin
          cnt_d = (SAT_MODE == MODE_SAT) ? MAX_C : ZERO_C;
        end else if (cnt_q > MAX_C) begin
          cnt_d = ZERO_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end else begin
        if (cnt_q == ZERO_C) begin
          cnt_d = (SAT_MODE == MODE_SAT) ? ZERO_C : MAX_C;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count and terminal-count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= ZERO_C;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.tick = tick_s;

endmodule
